// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (640x480@60 by default): registered position, sync,
// visible, line/frame strobes and a pausable frame counter, all on the pixel clock.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int SYNC_NEG  = 1,
    parameter int FRAME_W   = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pause,
    output logic [9:0]         hpos,
    output logic [9:0]         vpos,
    output logic               hsync,
    output logic               vsync,
    output logic               visible,
    output logic               line_tick,
    output logic               frame_tick,
    output logic [FRAME_W-1:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam logic SYNC_ON  = (SYNC_NEG != 0) ? 1'b0 : 1'b1;
    localparam logic SYNC_OFF = ~SYNC_ON;

    localparam logic [FRAME_W-1:0] FC_ONE = {{(FRAME_W-1){1'b0}}, 1'b1};

    function automatic logic in_window(input logic [9:0] pos,
                                       input logic [9:0] lo,
                                       input logic [9:0] hi);
        return (pos >= lo) && (pos < hi);
    endfunction

    function automatic logic sync_level(input logic active);
        return active ? SYNC_ON : SYNC_OFF;
    endfunction

    logic [9:0]         hc_r;
    logic [9:0]         vc_r;
    logic [9:0]         hc_nxt_s;
    logic [9:0]         vc_nxt_s;
    logic               hsync_s;
    logic               vsync_s;
    logic               visible_s;
    logic               line_tick_s;
    logic               frame_tick_s;
    logic [FRAME_W-1:0] fc_nxt_s;

    logic [9:0]         hpos_r;
    logic [9:0]         vpos_r;
    logic               hsync_r;
    logic               vsync_r;
    logic               visible_r;
    logic               line_tick_r;
    logic               frame_tick_r;
    logic [FRAME_W-1:0] frame_count_r;

    // Counter advance and decode of the current (hc, vc) into next output values.
    always_comb begin
        hc_nxt_s = hc_r + 10'd1;
        vc_nxt_s = vc_r;
        if (hc_r == H_LAST) begin
            hc_nxt_s = 10'd0;
            if (vc_r == V_LAST) begin
                vc_nxt_s = 10'd0;
            end else begin
                vc_nxt_s = vc_r + 10'd1;
            end
        end else begin
            vc_nxt_s = vc_r;
        end

        hsync_s      = sync_level(in_window(hc_r, HS_START, HS_END));
        vsync_s      = sync_level(in_window(vc_r, VS_START, VS_END));
        visible_s    = (hc_r < H_VIS) && (vc_r < V_VIS);
        line_tick_s  = (hc_r == 10'd0);
        frame_tick_s = (hc_r == 10'd0) && (vc_r == V_VIS);

        // The counter moves on the same edge that publishes frame_tick.
        if (frame_tick_s && !pause) begin
            fc_nxt_s = frame_count_r + FC_ONE;
        end else begin
            fc_nxt_s = frame_count_r;
        end
    end

    // Raster counters and the aligned output register stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hc_r          <= 10'd0;
            vc_r          <= 10'd0;
            hpos_r        <= 10'd0;
            vpos_r        <= 10'd0;
            hsync_r       <= SYNC_OFF;
            vsync_r       <= SYNC_OFF;
            visible_r     <= 1'b0;
            line_tick_r   <= 1'b0;
            frame_tick_r  <= 1'b0;
            frame_count_r <= '0;
        end else begin
            hc_r          <= hc_nxt_s;
            vc_r          <= vc_nxt_s;
            hpos_r        <= hc_r;
            vpos_r        <= vc_r;
            hsync_r       <= hsync_s;
            vsync_r       <= vsync_s;
            visible_r     <= visible_s;
            line_tick_r   <= line_tick_s;
            frame_tick_r  <= frame_tick_s;
            frame_count_r <= fc_nxt_s;
        end
    end

    assign hpos        = hpos_r;
    assign vpos        = vpos_r;
    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign visible     = visible_r;
    assign line_tick   = line_tick_r;
    assign frame_tick  = frame_tick_r;
    assign frame_count = frame_count_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-parameter instance for line timing and reset release,
// and a shrunken raster (100x13, active-high sync, FRAME_W=2) checked cycle by cycle via scoreboard.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- default-parameter instance ----------------
    logic       rst_n_d, pause_d;
    logic [9:0] hpos_d, vpos_d;
    logic       hsync_d, vsync_d, visible_d, line_tick_d, frame_tick_d;
    logic [9:0] frame_count_d;
    bit         d_done = 1'b0;

    vga_timing_gen dut_d (
        .clk(clk), .rst_n(rst_n_d), .pause(pause_d),
        .hpos(hpos_d), .vpos(vpos_d), .hsync(hsync_d), .vsync(vsync_d),
        .visible(visible_d), .line_tick(line_tick_d), .frame_tick(frame_tick_d),
        .frame_count(frame_count_d)
    );

    // ---------------- small raster instance ----------------
    localparam int S_HTOT = 100, S_HV = 64, S_HS0 = 72, S_HS1 = 88;
    localparam int S_VTOT = 13,  S_VV = 6,  S_VS0 = 8,  S_VS1 = 10;

    logic       rst_n_s, pause_s;
    logic [9:0] hpos_s, vpos_s;
    logic       hsync_s, vsync_s, visible_s, line_tick_s, frame_tick_s;
    logic [1:0] frame_count_s;

    vga_timing_gen #(
        .H_VISIBLE(64), .H_FRONT(8), .H_SYNC(16), .H_BACK(12),
        .V_VISIBLE(6),  .V_FRONT(2), .V_SYNC(2),  .V_BACK(3),
        .SYNC_NEG(0),   .FRAME_W(2)
    ) dut_s (
        .clk(clk), .rst_n(rst_n_s), .pause(pause_s),
        .hpos(hpos_s), .vpos(vpos_s), .hsync(hsync_s), .vsync(vsync_s),
        .visible(visible_s), .line_tick(line_tick_s), .frame_tick(frame_tick_s),
        .frame_count(frame_count_s)
    );

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       vis;
        logic       lt;
        logic       ft;
        logic [1:0] fc;
    } out_t;

    out_t exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected-response producer: one entry per clock edge, from the bench's own raster model.
    initial begin
        int   m_hc, m_vc, m_fc;
        out_t e;
        m_hc = 0; m_vc = 0; m_fc = 0;
        forever begin
            @(posedge clk);
            if (!rst_n_s) begin
                e = '0;
                m_hc = 0; m_vc = 0; m_fc = 0;
            end else begin
                e.h   = 10'(m_hc);
                e.v   = 10'(m_vc);
                e.hs  = (m_hc >= S_HS0) && (m_hc < S_HS1);
                e.vs  = (m_vc >= S_VS0) && (m_vc < S_VS1);
                e.vis = (m_hc < S_HV) && (m_vc < S_VV);
                e.lt  = (m_hc == 0);
                e.ft  = (m_hc == 0) && (m_vc == S_VV);
                if (e.ft && !pause_s) m_fc = (m_fc + 1) % 4;
                e.fc  = 2'(m_fc);
                m_hc++;
                if (m_hc == S_HTOT) begin
                    m_hc = 0;
                    m_vc++;
                    if (m_vc == S_VTOT) m_vc = 0;
                end
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: pops one expectation per cycle and compares away from the active edge.
    initial begin
        out_t e, got;
        int   prev_h, prev_v, cyc;
        prev_h = -1; prev_v = -1; cyc = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {hpos_s, vpos_s, hsync_s, vsync_s, visible_s, line_tick_s, frame_tick_s, frame_count_s};
                n_tests++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL sb cycle %0d: got h=%0d v=%0d hs=%b vs=%b vis=%b lt=%b ft=%b fc=%0d, expected h=%0d v=%0d hs=%b vs=%b vis=%b lt=%b ft=%b fc=%0d",
                             cyc, got.h, got.v, got.hs, got.vs, got.vis, got.lt, got.ft, got.fc,
                             e.h, e.v, e.hs, e.vs, e.vis, e.lt, e.ft, e.fc);
                end
                if (prev_h == S_HTOT - 1 && prev_v == S_VTOT - 1) begin
                    chk("wrap_h", int'(hpos_s), 0);
                    chk("wrap_v", int'(vpos_s), 0);
                    chk("wrap_vis", int'(visible_s), 1);
                end
                prev_h = int'(hpos_s);
                prev_v = int'(vpos_s);
                cyc++;
            end
        end
    end

    // Default instance: reset values, release, and one full 800-clock line.
    initial begin
        int hs_low, hs_first, hs_last, vis_low, c;
        bit seen;
        rst_n_d = 1'b0; pause_d = 1'b0;
        repeat (3) @(negedge clk);
        chk("d_rst_hpos", int'(hpos_d), 0);
        chk("d_rst_hsync", int'(hsync_d), 1);
        chk("d_rst_vsync", int'(vsync_d), 1);
        chk("d_rst_visible", int'(visible_d), 0);
        chk("d_rst_line_tick", int'(line_tick_d), 0);
        chk("d_rst_fc", int'(frame_count_d), 0);
        rst_n_d = 1'b1;
        @(negedge clk);
        chk("d_rel_hpos", int'(hpos_d), 0);
        chk("d_rel_vpos", int'(vpos_d), 0);
        chk("d_rel_visible", int'(visible_d), 1);
        chk("d_rel_line_tick", int'(line_tick_d), 1);
        chk("d_rel_hsync", int'(hsync_d), 1);
        chk("d_rel_vsync", int'(vsync_d), 1);
        chk("d_rel_fc", int'(frame_count_d), 0);
        hs_low = 0; hs_first = -1; hs_last = -1; vis_low = 0; seen = 1'b0; c = 0;
        for (int k = 1; k <= 1000; k++) begin
            @(negedge clk);
            if (line_tick_d) begin
                seen = 1'b1;
                c = k;
                break;
            end
            if (!hsync_d) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(hpos_d);
                hs_last = int'(hpos_d);
            end
            if (!visible_d) vis_low++;
        end
        chk("d_line_tick_seen", int'(seen), 1);
        chk("d_line_period", c, 800);
        chk("d_line2_vpos", int'(vpos_d), 1);
        chk("d_hsync_width", hs_low, 96);
        chk("d_hsync_first", hs_first, 656);
        chk("d_hsync_last", hs_last, 751);
        chk("d_visible_low", vis_low, 160);
        d_done = 1'b1;
    end

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (frame_tick_s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Small instance stimulus: frame sequence with wrap, pause, mid-frame reset.
    initial begin
        bit ok, found;
        int seq[5];
        seq = '{1, 2, 3, 0, 1};
        rst_n_s = 1'b0; pause_s = 1'b0;
        repeat (3) @(negedge clk);
        rst_n_s = 1'b1;

        for (int i = 0; i < 5; i++) begin
            wait_tick(ok);
            chk($sformatf("tick_seen_%0d", i), int'(ok), 1);
            chk($sformatf("fc_seq_%0d", i), int'(frame_count_s), seq[i]);
            chk($sformatf("tick_vpos_%0d", i), int'(vpos_s), 6);
        end

        pause_s = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wait_tick(ok);
            chk("pause_tick_seen", int'(ok), 1);
            chk("fc_paused", int'(frame_count_s), 1);
        end
        pause_s = 1'b0;
        wait_tick(ok);
        chk("resume_tick_seen", int'(ok), 1);
        chk("fc_resume", int'(frame_count_s), 2);

        found = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (hpos_s == 10'd30 && vpos_s == 10'd3) begin
                found = 1'b1;
                break;
            end
        end
        chk("mid_point_found", int'(found), 1);
        rst_n_s = 1'b0;
        @(negedge clk);
        rst_n_s = 1'b1;
        chk("mid_rst_hpos", int'(hpos_s), 0);
        chk("mid_rst_vpos", int'(vpos_s), 0);
        chk("mid_rst_visible", int'(visible_s), 0);
        chk("mid_rst_fc", int'(frame_count_s), 0);
        @(negedge clk);
        chk("mid_rel_visible", int'(visible_s), 1);
        chk("mid_rel_line_tick", int'(line_tick_s), 1);
        chk("mid_rel_hpos", int'(hpos_s), 0);
        wait_tick(ok);
        chk("mid_tick_seen", int'(ok), 1);
        chk("mid_fc_first", int'(frame_count_s), 1);
        repeat (1400) @(negedge clk);

        chk("default_bench_done", int'(d_done), 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
